// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg
// Description : Shared widths, default timing constants and ringing-FSM state
//               encoding for the alarm snooze controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

   // Time-field widths shared with the upstream 12-hour timekeeping block
   localparam int HOUR_W = 4;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   localparam int RING_TIMEOUT_D = 60;
   localparam int SNOOZE_MIN_D   = 5;
   localparam int MAX_SNOOZE_D   = 3;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_RINGING  = 2'd1;
   localparam logic [1:0] ST_SNOOZING = 2'd2;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      RINGING  = ST_RINGING,
      SNOOZING = ST_SNOOZING
   } alarm_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rise_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_edge_detect
// Description : One-cycle pulse on the rising edge of a debounced level.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_edge_detect (
   input  logic clock_sec,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic r_in_q;

   // History resets low so a level held through reset release yields one pulse
   always_ff @(posedge clock_sec or negedge reset) begin
      if (!reset) begin
         r_in_q <= 1'b0;
      end else begin
         r_in_q <= in;
      end
   end

   assign pulse = in & ~r_in_q;

endmodule
`default_nettype wire

// File: rtl/alarm_snooze_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_snooze_controller
// Description : Alarm ringing FSM with enable, stop, limited timed snooze,
//               ring timeout and a sticky missed-alarm flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_snooze_controller
   import alarm_pkg::*;
#(
   parameter int RING_TIMEOUT = RING_TIMEOUT_D,
   parameter int SNOOZE_MIN   = SNOOZE_MIN_D,
   parameter int MAX_SNOOZE   = MAX_SNOOZE_D
) (
   input  logic              clock_sec,
   input  logic              reset,
   input  logic [HOUR_W-1:0] hours,
   input  logic [MIN_W-1:0]  minutes,
   input  logic [SEC_W-1:0]  seconds,
   input  logic              am_pm,
   input  logic [HOUR_W-1:0] alarm_hour,
   input  logic [MIN_W-1:0]  alarm_minute,
   input  logic              alarm_am_pm,
   input  logic              alarm_enable,
   input  logic              snooze,
   input  logic              stop,
   output logic              alarm_ringing,
   output logic              snooze_active,
   output logic [1:0]        snooze_count,
   output logic              alarm_missed
);

   localparam int c_SNOOZE_LEN = SNOOZE_MIN * 60;
   localparam int c_RING_W     = max_int($clog2(RING_TIMEOUT), 1);
   localparam int c_SNZ_W      = max_int($clog2(c_SNOOZE_LEN), 10);

   localparam logic [c_RING_W-1:0] c_RING_LAST  = c_RING_W'(RING_TIMEOUT - 1);
   localparam logic [c_SNZ_W-1:0]  c_SNZ_LOAD   = c_SNZ_W'(c_SNOOZE_LEN - 1);
   localparam logic [1:0]          c_MAX_SNOOZE = 2'(MAX_SNOOZE);

   alarm_state_e        r_state;
   alarm_state_e        w_state_nxt;
   logic [c_RING_W-1:0] r_ring_cnt;
   logic [c_RING_W-1:0] w_ring_cnt_nxt;
   logic [c_SNZ_W-1:0]  r_snz_cnt;
   logic [c_SNZ_W-1:0]  w_snz_cnt_nxt;
   logic [1:0]          r_snooze_count;
   logic [1:0]          w_snooze_count_nxt;
   logic                r_alarm_missed;
   logic                w_alarm_missed_nxt;
   logic                w_snooze_e;
   logic                w_stop_e;
   logic                w_match;

   rise_edge_detect u_snooze_edge (
      .clock_sec (clock_sec),
      .reset     (reset),
      .in        (snooze),
      .pulse     (w_snooze_e)
   );

   rise_edge_detect u_stop_edge (
      .clock_sec (clock_sec),
      .reset     (reset),
      .in        (stop),
      .pulse     (w_stop_e)
   );

   // seconds==0 restricts the trigger to a single edge per matching minute
   assign w_match = alarm_enable
                  & (hours   == alarm_hour)
                  & (minutes == alarm_minute)
                  & (am_pm   == alarm_am_pm)
                  & (seconds == '0);

   always_comb begin
      w_state_nxt        = r_state;
      w_ring_cnt_nxt     = r_ring_cnt;
      w_snz_cnt_nxt      = r_snz_cnt;
      w_snooze_count_nxt = r_snooze_count;
      w_alarm_missed_nxt = r_alarm_missed;

      if (!alarm_enable) begin
         // Disarm overrides everything but keeps the missed flag for the user
         w_state_nxt        = IDLE;
         w_snooze_count_nxt = 2'd0;
      end else begin
         if (w_stop_e) begin
            w_alarm_missed_nxt = 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_match) begin
                  w_state_nxt        = RINGING;
                  w_ring_cnt_nxt     = '0;
                  w_snooze_count_nxt = 2'd0;
                  w_alarm_missed_nxt = 1'b0;
               end
            end

            RINGING: begin
               if (w_stop_e) begin
                  w_state_nxt        = IDLE;
                  w_snooze_count_nxt = 2'd0;
               end else if (w_snooze_e && (r_snooze_count < c_MAX_SNOOZE)) begin
                  w_state_nxt        = SNOOZING;
                  w_snooze_count_nxt = r_snooze_count + 2'd1;
                  w_snz_cnt_nxt      = c_SNZ_LOAD;
               end else if (r_ring_cnt == c_RING_LAST) begin
                  w_state_nxt        = IDLE;
                  w_alarm_missed_nxt = 1'b1;
               end else begin
                  w_ring_cnt_nxt = r_ring_cnt + 1'b1;
               end
            end

            SNOOZING: begin
               if (w_stop_e) begin
                  w_state_nxt        = IDLE;
                  w_snooze_count_nxt = 2'd0;
               end else if (r_snz_cnt == '0) begin
                  w_state_nxt    = RINGING;
                  w_ring_cnt_nxt = '0;
               end else begin
                  w_snz_cnt_nxt = r_snz_cnt - 1'b1;
               end
            end

            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock_sec or negedge reset) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_ring_cnt     <= '0;
         r_snz_cnt      <= '0;
         r_snooze_count <= 2'd0;
         r_alarm_missed <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_ring_cnt     <= w_ring_cnt_nxt;
         r_snz_cnt      <= w_snz_cnt_nxt;
         r_snooze_count <= w_snooze_count_nxt;
         r_alarm_missed <= w_alarm_missed_nxt;
      end
   end

   assign alarm_ringing = (r_state == RINGING);
   assign snooze_active = (r_state == SNOOZING);
   assign snooze_count  = r_snooze_count;
   assign alarm_missed  = r_alarm_missed;

endmodule
`default_nettype wire

// File: tb/tb_alarm_snooze_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_snooze_controller
// Description : Directed and randomized bench for alarm_snooze_controller
//               against a timestamp-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_snooze_controller;

   localparam int RT      = 60;
   localparam int SNZ_LEN = 300;
   localparam int MAXS    = 3;

   logic       clock_sec = 1'b0;
   logic       reset     = 1'b0;
   logic [3:0] hours, alarm_hour;
   logic [5:0] minutes, seconds, alarm_minute;
   logic       am_pm, alarm_am_pm, alarm_enable, snooze, stop;
   logic       alarm_ringing, snooze_active, alarm_missed;
   logic [1:0] snooze_count;

   int n_checks = 0;
   int n_fail   = 0;
   int tod      = 0;
   int cyc      = 0;

   // Reference model: event timestamps rather than down-counters
   bit m_ring, m_snz, m_missed, p_snooze, p_stop;
   int m_count, ring_start, snz_entry;

   alarm_snooze_controller dut (
      .clock_sec     (clock_sec),
      .reset         (reset),
      .hours         (hours),
      .minutes       (minutes),
      .seconds       (seconds),
      .am_pm         (am_pm),
      .alarm_hour    (alarm_hour),
      .alarm_minute  (alarm_minute),
      .alarm_am_pm   (alarm_am_pm),
      .alarm_enable  (alarm_enable),
      .snooze        (snooze),
      .stop          (stop),
      .alarm_ringing (alarm_ringing),
      .snooze_active (snooze_active),
      .snooze_count  (snooze_count),
      .alarm_missed  (alarm_missed)
   );

   always #5 clock_sec = ~clock_sec;

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic int alarm_tod();
      int ah;
      ah = (int'(alarm_hour) % 12) + (alarm_am_pm ? 12 : 0);
      return ah * 3600 + int'(alarm_minute) * 60;
   endfunction

   task automatic set_tod(input int t);
      int h24;
      tod     = ((t % 86400) + 86400) % 86400;
      h24     = tod / 3600;
      hours   = 4'((h24 % 12 == 0) ? 12 : h24 % 12);
      am_pm   = (h24 >= 12);
      minutes = 6'((tod / 60) % 60);
      seconds = 6'(tod % 60);
   endtask

   task automatic model_reset();
      m_ring = 0; m_snz = 0; m_missed = 0; m_count = 0;
      p_snooze = 0; p_stop = 0;
   endtask

   task automatic model_edge();
      bit se, st;
      if (!reset) begin
         model_reset();
      end else begin
         cyc++;
         se = snooze && !p_snooze;
         st = stop && !p_stop;
         p_snooze = snooze;
         p_stop   = stop;
         if (!alarm_enable) begin
            m_ring = 0; m_snz = 0; m_count = 0;
         end else begin
            if (st) m_missed = 0;
            if (m_ring) begin
               if (st) begin
                  m_ring = 0; m_count = 0;
               end else if (se && m_count < MAXS) begin
                  m_ring = 0; m_snz = 1; snz_entry = cyc; m_count++;
               end else if (cyc - ring_start == RT) begin
                  m_ring = 0; m_missed = 1;
               end
            end else if (m_snz) begin
               if (st) begin
                  m_snz = 0; m_count = 0;
               end else if (cyc - snz_entry == SNZ_LEN) begin
                  m_snz = 0; m_ring = 1; ring_start = cyc;
               end
            end else if (tod == alarm_tod()) begin
               m_ring = 1; ring_start = cyc; m_count = 0; m_missed = 0;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_sec);
      model_edge();
      #1;
      chk("model_ringing", {31'd0, alarm_ringing}, {31'd0, m_ring});
      chk("model_snoozing", {31'd0, snooze_active}, {31'd0, m_snz});
      chk("model_count", {30'd0, snooze_count}, 32'(m_count));
      chk("model_missed", {31'd0, alarm_missed}, {31'd0, m_missed});
      set_tod(tod + 1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_snooze();
      snooze = 1; step(); snooze = 0;
   endtask

   task automatic pulse_stop();
      stop = 1; step(); stop = 0;
   endtask

   task automatic trigger();
      set_tod(alarm_tod() - 1);
      for (int i = 0; i < 5; i++) begin
         if (alarm_ringing) break;
         step();
      end
      chk("trigger_ring", {31'd0, alarm_ringing}, 32'd1);
   endtask

   task automatic wait_ring(input int limit);
      for (int i = 0; i < limit; i++) begin
         if (alarm_ringing) break;
         step();
      end
      chk("wait_ring", {31'd0, alarm_ringing}, 32'd1);
   endtask

   int ring_len, gap;

   initial begin
      alarm_hour = 4'd7; alarm_minute = 6'd30; alarm_am_pm = 1'b0;
      alarm_enable = 1'b0; snooze = 1'b0; stop = 1'b0;
      model_reset();
      set_tod(0);

      // Reset state
      run(3);
      chk("reset_ringing", {31'd0, alarm_ringing}, 32'd0);
      chk("reset_count", {30'd0, snooze_count}, 32'd0);
      #3 reset = 1'b1;
      alarm_enable = 1'b1;

      // Untouched alarm rings for exactly RT cycles then flags missed
      set_tod(7 * 3600 + 29 * 60 + 50);
      ring_len = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (alarm_ringing) ring_len++;
         else if (ring_len > 0) break;
      end
      chk("ring_len", 32'(ring_len), 32'd60);
      chk("missed_after_timeout", {31'd0, alarm_missed}, 32'd1);

      // Snooze at ring cycle 10, ringing returns SNZ_LEN edges later, then stop
      trigger();
      run(9);
      pulse_snooze();
      chk("snz_active", {31'd0, snooze_active}, 32'd1);
      chk("snz_count1", {30'd0, snooze_count}, 32'd1);
      chk("snz_not_ringing", {31'd0, alarm_ringing}, 32'd0);
      gap = 0;
      for (int i = 0; i < 400; i++) begin
         step();
         gap++;
         if (alarm_ringing) break;
      end
      chk("snooze_gap", 32'(gap), 32'd300);
      pulse_stop();
      chk("stop_count", {30'd0, snooze_count}, 32'd0);
      chk("stop_idle", {31'd0, alarm_ringing}, 32'd0);

      // Snooze to the limit; fourth press is ignored and the ring times out
      trigger();
      for (int k = 0; k < MAXS; k++) begin
         run(5);
         pulse_snooze();
         wait_ring(400);
      end
      run(3);
      pulse_snooze();
      chk("limit_ringing", {31'd0, alarm_ringing}, 32'd1);
      chk("limit_count", {30'd0, snooze_count}, 32'd3);
      for (int i = 0; i < 100; i++) begin
         if (!alarm_ringing) break;
         step();
      end
      chk("limit_missed", {31'd0, alarm_missed}, 32'd1);

      // Stop and snooze on the same edge: stop wins
      trigger();
      run(3);
      snooze = 1; stop = 1; step(); snooze = 0; stop = 0;
      chk("both_ringing", {31'd0, alarm_ringing}, 32'd0);
      chk("both_snoozing", {31'd0, snooze_active}, 32'd0);
      chk("both_count", {30'd0, snooze_count}, 32'd0);
      chk("both_missed", {31'd0, alarm_missed}, 32'd0);

      // Stop on the timeout edge: stop wins, missed stays clear
      trigger();
      run(RT - 1);
      chk("pre_timeout_ringing", {31'd0, alarm_ringing}, 32'd1);
      pulse_stop();
      chk("timeout_stop_missed", {31'd0, alarm_missed}, 32'd0);
      chk("timeout_stop_ringing", {31'd0, alarm_ringing}, 32'd0);

      // Disarm while ringing and while snoozing; disarmed match never rings
      trigger();
      run(5);
      alarm_enable = 0; step();
      chk("dis_ring_ringing", {31'd0, alarm_ringing}, 32'd0);
      alarm_enable = 1;
      trigger();
      pulse_snooze();
      run(10);
      alarm_enable = 0; step();
      chk("dis_snz_active", {31'd0, snooze_active}, 32'd0);
      chk("dis_snz_count", {30'd0, snooze_count}, 32'd0);
      set_tod(alarm_tod() - 2);
      run(5);
      chk("dis_match_ringing", {31'd0, alarm_ringing}, 32'd0);
      alarm_enable = 1;

      // Asynchronous reset mid-snooze, released with the snooze button held
      trigger();
      pulse_snooze();
      run(20);
      #3 reset = 1'b0;
      #1;
      model_reset();
      chk("async_snoozing", {31'd0, snooze_active}, 32'd0);
      chk("async_count", {30'd0, snooze_count}, 32'd0);
      chk("async_ringing", {31'd0, alarm_ringing}, 32'd0);
      snooze = 1;
      run(2);
      #3 reset = 1'b1;
      run(3);
      chk("held_snooze_idle", {31'd0, snooze_active}, 32'd0);
      snooze = 0;
      run(2);

      // Randomized episodes around random alarm settings
      for (int ep = 0; ep < 30; ep++) begin
         alarm_hour   = 4'($urandom_range(1, 12));
         alarm_minute = 6'($urandom_range(0, 59));
         alarm_am_pm  = 1'($urandom_range(0, 1));
         set_tod(alarm_tod() - int'($urandom_range(1, 4)));
         for (int i = 0; i < 420; i++) begin
            snooze       = ($urandom_range(0, 7) == 0);
            stop         = ($urandom_range(0, 59) == 0);
            alarm_enable = ($urandom_range(0, 149) != 0);
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alarm_snooze_controller.md
Name: alarm_snooze_controller

Overview:
- Sits directly downstream of the 12-hour timekeeping block. Consumes hours/minutes/seconds/am_pm and the alarm setting on the same 1 Hz clock_sec.
- Replaces the bare combinational time-equals-alarm compare with a ringing FSM. The FSM adds enable, stop, a timed snooze with a snooze limit, ring timeout, and a sticky missed-alarm flag.

Parameters:
- RING_TIMEOUT, 60, clock_sec cycles the alarm rings with no user action before giving up.
- SNOOZE_MIN, 5, snooze length in minutes; the countdown is SNOOZE_MIN*60 cycles.
- MAX_SNOOZE, 3, maximum snoozes per alarm event.

Ports:
- clock_sec  in  1  1 Hz clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- hours  in  4  current hour, 1..12
- minutes  in  6  current minute, 0..59
- seconds  in  6  current second, 0..59
- am_pm  in  1  0 = am, 1 = pm
- alarm_hour  in  4  alarm hour, 1..12
- alarm_minute  in  6  alarm minute, 0..59
- alarm_am_pm  in  1  alarm am/pm
- alarm_enable  in  1  level; 0 disarms and silences immediately
- snooze  in  1  debounced button level
- stop  in  1  debounced button level
- alarm_ringing  out  1  registered; high while in RINGING
- snooze_active  out  1  registered; high while in SNOOZING
- snooze_count  out  2  snoozes used in the current event
- alarm_missed  out  1  sticky; set on ring timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; ring_cnt=0; snooze_cnt(10b)=0.
  - All outputs 0; button history registers = 0.
- Button edges:
  - snooze_e = snooze & ~snooze_q; stop_e = stop & ~stop_q.
  - snooze_q and stop_q are updated every edge.
  - A button held through reset release counts as one edge on the first clock.
- match = alarm_enable & (hours==alarm_hour) & (minutes==alarm_minute) & (am_pm==alarm_am_pm) & (seconds==0).
  - The seconds==0 term guarantees one trigger per matching minute.
- Global override: alarm_enable=0 at any edge -> IDLE.
  - alarm_ringing=0, snooze_active=0, snooze_count=0.
  - alarm_missed is held, not cleared.
- IDLE:
  - match -> RINGING; ring_cnt=0; snooze_count=0; alarm_missed=0.
  - alarm_ringing is high from the edge that samples match (1-cycle latency).
- RINGING, in priority order:
  - stop_e -> IDLE; snooze_count=0.
  - snooze_e and snooze_count<MAX_SNOOZE -> SNOOZING; snooze_count+1; snooze_cnt=SNOOZE_MIN*60-1.
  - snooze_e at snooze_count==MAX_SNOOZE is ignored; ringing continues and ring_cnt keeps running.
  - ring_cnt==RING_TIMEOUT-1 -> IDLE; alarm_missed=1. Ringing therefore lasts exactly RING_TIMEOUT cycles.
  - otherwise ring_cnt+1.
- SNOOZING:
  - stop_e -> IDLE; snooze_count=0.
  - snooze_cnt==0 -> RINGING; ring_cnt=0. Ringing resumes exactly SNOOZE_MIN*60 edges after the edge that entered SNOOZING.
  - otherwise snooze_cnt-1.
  - snooze_e is ignored.
  - match during SNOOZING is ignored (no double event).
- alarm_missed clears on a stop_e edge in any state, or on a new trigger from IDLE.
- Simultaneous stop_e and snooze_e: stop wins.
- Timeout and stop_e on the same edge: stop wins; alarm_missed stays 0.
- Counter widths:
  - ring_cnt = clog2(RING_TIMEOUT).
  - snooze_cnt = clog2(SNOOZE_MIN*60), with a minimum of 10b at default.
  - No counter wraps; every terminal value forces a transition.
- Time set upstream mid-event does not affect the FSM. A set that produces seconds==0 with a matching time while in IDLE triggers normally.

Decomposition:
- Package alarm_pkg:
  - state enum {IDLE, RINGING, SNOOZING}, 2b encoding.
  - Default constants RING_TIMEOUT_D, SNOOZE_MIN_D, MAX_SNOOZE_D.
  - Hour/minute width constants shared with the timekeeping block.
- One sub-module: rise_edge_detect (clock_sec, reset, in -> pulse), instantiated twice for stop and snooze.

Test Plan:
- Reset, then alarm 7:30 am, enable=1; drive 7:29:59 am -> 7:30:00 am.
  - alarm_ringing=1 on the next edge, and it stays high for exactly 60 cycles.
  - Then alarm_ringing=0 and alarm_missed=1.
- Ringing; snooze pulse at ring cycle 10.
  - snooze_active=1, snooze_count=1, alarm_ringing=0.
  - alarm_ringing returns exactly 300 edges later.
  - stop pulse -> IDLE, snooze_count=0.
- Snooze 3 times to the limit, then a 4th snooze pulse while ringing.
  - Ignored; alarm_ringing stays 1, snooze_count=3.
  - Timeout after 60 cycles -> alarm_missed=1.
- stop and snooze rising on the same edge while ringing -> IDLE, snooze_count=0, alarm_missed=0.
- Ringing or snoozing, drop alarm_enable -> all outputs 0 next edge.
  - Drive a matching time with enable=0 -> no ring.
- Assert reset=0 asynchronously mid-SNOOZING (not aligned to clock_sec) -> outputs 0 immediately.
  - After release with the snooze button held high: one edge is detected, and it is ignored in IDLE.
